fifo_uart_tx: RTL
=================

# fifo_uart_tx

Drain-side serializer that sits directly downstream of the 8-deep byte FIFO. It pops bytes through the FIFO's `r_en`/`empty`/`d_out` handshake and transmits each byte as an asynchronous UART frame: start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits. The block is the FIFO's only reader, and it shares the FIFO's clock and reset.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit. Legal range is 2..65535.
- `PARITY`, default 0: parity mode. 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.

- `clk`  in  1  single system clock; all logic is on its rising edge.
- `rst`  in  1  reset. **Synchronous, active-high.**
- `tx_en`  in  1  when low, no new frame starts; a frame already in flight completes.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_d_out`  in  8  FIFO registered read data; valid the cycle after the FIFO samples `r_en`.
- `fifo_r_en`  out  1  FIFO read request. Registered; high for exactly one cycle per byte.
- `tx`  out  1  serial line. Registered; idles high.
- `busy`  out  1  high from the request cycle through the last stop-bit cycle.
- `tx_done`  out  1  one-cycle pulse after the final stop bit of each frame.

## Operation
- States are IDLE, REQ, WAIT, START, DATA, PARITY, STOP.
- **IDLE**
  - Outputs: `tx`=1, `busy`=0.
  - If `tx_en` and `!fifo_empty`, set `fifo_r_en`<=1 and go to REQ.
- **REQ**
  - `fifo_r_en` is 1 this cycle; the FIFO samples it at the closing edge.
  - Set `fifo_r_en`<=0 and go to WAIT.
- **WAIT**
  - Capture `fifo_d_out` into the 8-bit shift register.
  - Compute the parity bit: XOR of the data bits, inverted for odd parity.
  - Go to START.
- **START**: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- **DATA**
  - `tx`=shift[0] for each bit period, then shift right.
  - 3-bit bit index; after 8 bits go to PARITY if `PARITY`≠0, else STOP.
- **PARITY**: `tx`=parity bit for one bit period, then go to STOP.
- **STOP**: `tx`=1 for `STOP_BITS` bit periods, then go to IDLE with `tx_done`<=1.
- **Baud counter**
  - Width is `$clog2(CLKS_PER_BIT)`.
  - Cleared on every state entry.
  - The bit-period boundary is the cycle where count == `CLKS_PER_BIT`-1.
  - No cumulative drift: every bit lasts exactly `CLKS_PER_BIT` cycles.
- **Read safety**
  - `fifo_r_en` is issued only after seeing `fifo_empty`=0 in IDLE.
  - Because this block is the only reader, the byte is guaranteed present.
  - A second `fifo_r_en` is never issued before the current frame's STOP completes.
- **`tx_en` deasserted mid-frame**: no effect until IDLE; no new request is made while it stays low.

## Timing
- **Reset values**
  - Outputs: `tx`=1, `fifo_r_en`=0, `busy`=0, `tx_done`=0.
  - State IDLE; counters and shift register cleared.
  - Reset anywhere mid-frame drives `tx` high on the next cycle and drops the partial byte.
  - The FIFO shares `rst`, so no dangling read exists.
- **Start latency**: `fifo_empty` seen low in IDLE at cycle t gives:
  - `fifo_r_en`=1 at t+1;
  - capture at t+2;
  - `tx` falls at t+3.
- **Frame length**: (1+8+(PARITY≠0)+STOP_BITS)×`CLKS_PER_BIT` cycles.
- **Back-to-back frames**
  - `tx_done` pulses in the IDLE cycle after the stop bit.
  - If the FIFO is non-empty, the next start bit begins 3 cycles after the stop bit ends.
  - The line stays high during those 3 cycles.
- **Simultaneous FIFO write and read**: a write and the pop landing on the same edge need no special handling here; `fifo_empty` is only trusted in IDLE.
- **Width rule**: the bit index wraps 7→0 only on the DATA exit transition.

## Structure
- **Package `uart_pkg`**
  - State enum `tx_state_t`.
  - Parity-mode constants `PAR_NONE`/`PAR_EVEN`/`PAR_ODD`.
  - `UART_DATA_W`=8.
- **Sub-module `uart_baud_gen`**
  - Parameterized by `CLKS_PER_BIT`.
  - Inputs `clk`, `rst`, `clear`; output `tick` at end of bit period.
  - Instantiated once.
- **FSM, shift register and parity** live in `fifo_uart_tx`.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and an FIFO model with a registered `d_out`.
- **Reset**: hold `rst` 3 cycles with the FIFO non-empty. Outputs stay `tx`=1, `fifo_r_en`=0, `busy`=0, `tx_done`=0; the first `fifo_r_en` comes 1 cycle after `rst` falls.
- **Single byte, default parameters**: push 0xA5. Expect `tx` = 0 ×4, then data 1,0,1,0,0,1,0,1 (4 cycles each), then 1 ×4; exactly one `fifo_r_en`; `tx_done` one cycle after the stop bit.
- **Even and odd parity**
  - `PARITY`=1 with 0xA5: parity bit 0.
  - `PARITY`=2 with 0xA5: parity bit 1.
  - `PARITY`=1 with 0x07: parity bit 1.
  - Frame length is 44 cycles with 1 stop bit.
- **Burst of 8 bytes (FIFO full)**
  - Push 0x00..0x07. Expect 8 frames in order, each separated by exactly 3 idle-high cycles.
  - Exactly 8 `fifo_r_en` pulses; `fifo_empty` rises after the 8th pop.
  - Never more than one read outstanding.
- **`tx_en` gating**
  - Drop `tx_en` mid-frame: the current frame completes and no further `fifo_r_en` is issued.
  - Raise `tx_en`: `tx` falls 3 cycles later.
- **Mid-frame reset**
  - Assert `rst` during DATA bit 3: `tx`=1 on the next cycle, `busy`=0, no `tx_done`.
  - After release, an empty FIFO means no request is issued.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package uart_pkg;

   localparam int unsigned UART_DATA_W = 8;

   // Parity modes
   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_EVEN = 1;
   localparam int unsigned PAR_ODD  = 2;

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StWait,
      StStart,
      StData,
      StParity,
      StStop
   } tx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: tick marks the last cycle of each CLKS_PER_BIT-long bit.
// The count restarts on clear (state entry) and after each tick, so bit
// periods never drift relative to one another.
module uart_baud_gen #(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == CntMax);

   // Next count: restart on clear or at the end of a bit period
   always_comb begin
      cnt_d = cnt_q + CntW'(1);
      if (clear || tick) begin
         cnt_d = '0;
      end
   end

   // Counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the upstream FIFO and sends each as a UART frame:
// start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
module fifo_uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   tx_en,
   input  logic                   fifo_empty,
   input  logic [UART_DATA_W-1:0] fifo_d_out,
   output logic                   fifo_r_en,
   output logic                   tx,
   output logic                   busy,
   output logic                   tx_done
);

   localparam logic [2:0] LastStop = 3'(STOP_BITS - 1);

   tx_state_t              state_q, state_d;
   logic [UART_DATA_W-1:0] shift_q, shift_d;
   logic                   parity_q, parity_d;
   logic [2:0]             idx_q, idx_d;
   logic                   tx_q, tx_d;
   logic                   r_en_q, r_en_d;
   logic                   done_q, done_d;
   logic                   tick;
   logic                   baud_clear;

   // Every state change restarts the bit timer
   assign baud_clear = (state_d != state_q);

   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_gen (
      .clk  (clk),
      .rst  (rst),
      .clear(baud_clear),
      .tick (tick)
   );

   // Next-state, shift register, parity and bit/stop index
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      parity_d = parity_q;
      idx_d    = idx_q;
      r_en_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            // Sole reader: a non-empty flag seen here guarantees the byte exists
            if (tx_en && !fifo_empty) begin
               r_en_d  = 1'b1;
               state_d = StReq;
            end
         end
         StReq: begin
            state_d = StWait;
         end
         StWait: begin
            shift_d  = fifo_d_out;
            parity_d = (^fifo_d_out) ^ (PARITY == PAR_ODD);
            state_d  = StStart;
         end
         StStart: begin
            if (tick) begin
               idx_d   = 3'd0;
               state_d = StData;
            end
         end
         StData: begin
            if (tick) begin
               shift_d = shift_q >> 1;
               if (idx_q == 3'd7) begin
                  idx_d   = 3'd0;
                  state_d = (PARITY != PAR_NONE) ? StParity : StStop;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         StParity: begin
            if (tick) begin
               idx_d   = 3'd0;
               state_d = StStop;
            end
         end
         StStop: begin
            // idx counts stop bits here
            if (tick) begin
               if (idx_q == LastStop) begin
                  idx_d   = 3'd0;
                  state_d = StIdle;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Line level for the next cycle follows the state being entered
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         StStart:  tx_d = 1'b0;
         StData:   tx_d = shift_d[0];
         StParity: tx_d = parity_d;
         default:  tx_d = 1'b1;
      endcase
      done_d = (state_q == StStop) && (state_d == StIdle);
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         shift_q  <= '0;
         parity_q <= 1'b0;
         idx_q    <= 3'd0;
         tx_q     <= 1'b1;
         r_en_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         parity_q <= parity_d;
         idx_q    <= idx_d;
         tx_q     <= tx_d;
         r_en_q   <= r_en_d;
         done_q   <= done_d;
      end
   end

   assign fifo_r_en = r_en_q;
   assign tx        = tx_q;
   assign tx_done   = done_q;
   assign busy      = (state_q != StIdle);

endmodule
